ranger_patrol: RTL and testbench

RANGER_PATROL -- requirements
Module: ranger_patrol

---
 rtl/ranger_patrol.sv | 160 ++++++++++++++++
 tb/tb_ranger_patrol.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ranger_patrol.sv
// ranger_patrol: a set of NUM_RANGERS patrolling sprites. Each ranger walks
// back and forth along one axis, between 0 and PATROL_SPAN pixels from its
// initial position. It moves STEP pixels on every movement tick, and a tick
// occurs every STEP_DIV clocks.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rangerNum  1-based ranger select (0 or >NUM_RANGERS selects nothing)
//   inputs     bit0 freeze, bit1 respawn, bits3:2 ignored
//   position   registered {hpos, vpos} of the selected ranger
//   pos_valid  registered: position refers to a real ranger
//   tick       registered single-cycle pulse per movement tick

// One ranger: an 8-bit offset and a FWD/BACK direction state.
module ranger_lane #(
  parameter bit          HORIZ       = 1'b1,
  parameter int          STEP        = 2,
  parameter int          PATROL_SPAN = 64,
  parameter logic [19:0] INIT        = 20'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        respawn,
  output logic [19:0] pos
);
  typedef enum logic {FWD, BACK} dir_t;

  dir_t       dir;
  logic [7:0] offset;
  logic [8:0] fwd_sum;
  logic [9:0] off10;

  // 9-bit sum so that offset+STEP cannot wrap before the span compare.
  assign fwd_sum = {1'b0, offset} + 9'(STEP);
  assign off10   = {2'b0, offset};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= 8'd0;
      dir    <= FWD;
    end else if (respawn) begin
      offset <= 8'd0;
      dir    <= FWD;
    end else if (advance) begin
      case (dir)
        FWD: begin
          if (fwd_sum < 9'(PATROL_SPAN)) begin
            offset <= fwd_sum[7:0];
          end else begin
            offset <= 8'(PATROL_SPAN);
            dir    <= BACK;
          end
        end
        BACK: begin
          if (offset > 8'(STEP)) begin
            offset <= offset - 8'(STEP);
          end else begin
            offset <= 8'd0;
            dir    <= FWD;
          end
        end
        default: dir <= FWD;
      endcase
    end
  end

  always_comb begin
    pos = INIT;
    if (HORIZ) pos[19:10] = INIT[19:10] + off10;
    else       pos[9:0]   = INIT[9:0] + off10;
  end
endmodule

module ranger_patrol #(
  parameter int NUM_RANGERS = 5,
  parameter int STEP_DIV    = 416667,
  parameter int STEP        = 2,
  parameter int PATROL_SPAN = 64,
  parameter logic [NUM_RANGERS*20-1:0] INIT_POS = {
    10'd368, 10'd383,
    10'd256, 10'd447,
    10'd624, 10'd329,
    10'd672, 10'd127,
    10'd368, 10'd127}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rangerNum,
  input  logic [3:0]  inputs,
  output logic [19:0] position,
  output logic        pos_valid,
  output logic        tick
);
  localparam int CW = $clog2(STEP_DIV);

  logic [CW-1:0] cnt;
  logic          tick_int;
  logic          freeze, respawn;
  logic          unused_inputs;
  logic [NUM_RANGERS-1:0][19:0] lane_pos;
  logic [19:0]   sel_pos;
  logic          sel_valid;

  assign freeze        = inputs[0];
  assign respawn       = inputs[1];
  assign unused_inputs = &{1'b0, inputs[3:2]};
  assign tick_int      = (cnt == CW'(STEP_DIV - 1));

  // Free-running divider; it keeps counting while frozen, and a respawn restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tick_int;
      if (respawn || tick_int) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
    end
  end

  // Ranger k (1-based) has odd k on the horizontal axis: index 0 is ranger 1.
  for (genvar k = 0; k < NUM_RANGERS; k++) begin : g_lane
    ranger_lane #(
      .HORIZ      ((k % 2) == 0),
      .STEP       (STEP),
      .PATROL_SPAN(PATROL_SPAN),
      .INIT       (INIT_POS[20*k +: 20])
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .advance(tick_int && !freeze),
      .respawn(respawn),
      .pos    (lane_pos[k])
    );
  end

  always_comb begin
    sel_pos   = 20'd0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_RANGERS; k++) begin
      if (rangerNum == 3'(k + 1)) begin
        sel_pos   = lane_pos[k];
        sel_valid = 1'b1;
      end
    end
  end

  // The output is sampled from the lane state that holds before this edge's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position  <= 20'd0;
      pos_valid <= 1'b0;
    end else begin
      position  <= sel_pos;
      pos_valid <= sel_valid;
    end
  end
endmodule

// File: tb/tb_ranger_patrol.sv
module tb_ranger_patrol;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rangerNum = 3'd1;
  logic [3:0]  inputs = 4'd0;
  logic [19:0] position;
  logic        pos_valid;
  logic        tick;

  int vectors = 0;
  int miscompares = 0;

  ranger_patrol #(
    .NUM_RANGERS(5),
    .STEP_DIV   (4),
    .STEP       (2),
    .PATROL_SPAN(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rangerNum(rangerNum),
    .inputs   (inputs),
    .position (position),
    .pos_valid(pos_valid),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hv(input int h, input int v);
    return {12'd0, 10'(h), 10'(v)};
  endfunction

  int hexp [7] = '{370, 372, 374, 372, 370, 368, 370};

  initial begin
    // reset held across clock edges
    step(2);
    check("rst_pos",   {12'd0, position}, 32'd0);
    check("rst_valid", {31'd0, pos_valid}, 32'd0);
    check("rst_tick",  {31'd0, tick}, 32'd0);
    rst = 1'b0;

    // edge 1 after release: initial position, no motion yet
    step(1);
    check("init_pos",   {12'd0, position}, hv(368, 127));
    check("init_valid", {31'd0, pos_valid}, 32'd1);
    step(2);
    check("tick_e3", {31'd0, tick}, 32'd0);
    step(1);
    check("tick_e4", {31'd0, tick}, 32'd1);

    // ranger 1 patrol, sampled one edge after each tick
    step(1);
    for (int m = 0; m < 7; m++) begin
      check($sformatf("r1_tick%0d", m + 1), {12'd0, position}, hv(hexp[m], 127));
      if (m == 0) check("tick_off", {31'd0, tick}, 32'd0);
      if (m == 1) begin
        rangerNum = 3'd2;
        step(1);
        check("r2_vert", {12'd0, position}, hv(672, 131));
        rangerNum = 3'd1;
        step(3);
      end else begin
        step(4);
      end
    end
    // edge 33: offset 4, FWD
    check("r1_e33", {12'd0, position}, hv(372, 127));

    // freeze across three ticks (edges 36, 40, 44)
    inputs = 4'b0001;
    step(3);
    check("frz_tick1", {31'd0, tick}, 32'd1);
    check("frz_pos1",  {12'd0, position}, hv(372, 127));
    step(1);
    check("frz_tick_lo", {31'd0, tick}, 32'd0);
    step(3);
    check("frz_tick2", {31'd0, tick}, 32'd1);
    step(4);
    check("frz_tick3", {31'd0, tick}, 32'd1);
    check("frz_pos3",  {12'd0, position}, hv(372, 127));
    inputs = 4'b0000;
    // resume FWD from 4: 6 then back to 4
    step(5);
    check("resume1", {12'd0, position}, hv(374, 127));
    step(4);
    check("resume2", {12'd0, position}, hv(372, 127));

    // respawn coincident with a tick while frozen (cycle before edge 56)
    step(2);
    inputs = 4'b0011;
    step(1);
    inputs = 4'b0000;
    step(1);
    check("respawn_pos", {12'd0, position}, hv(368, 127));
    step(2);
    check("resp_tick_e59", {31'd0, tick}, 32'd0);
    step(1);
    check("resp_tick_e60", {31'd0, tick}, 32'd1);
    step(1);
    check("resp_move", {12'd0, position}, hv(370, 127));
    rangerNum = 3'd3;
    step(1);
    check("r3_horiz", {12'd0, position}, hv(626, 329));
    rangerNum = 3'd4;
    step(1);
    check("r4_vert", {12'd0, position}, hv(256, 449));

    // invalid selects
    rangerNum = 3'd0;
    step(1);
    check("sel0_pos",   {12'd0, position}, 32'd0);
    check("sel0_valid", {31'd0, pos_valid}, 32'd0);
    rangerNum = 3'd6;
    step(1);
    check("sel6_pos",   {12'd0, position}, 32'd0);
    check("sel6_valid", {31'd0, pos_valid}, 32'd0);
    rangerNum = 3'd1;
    step(1);
    check("sel1_valid", {31'd0, pos_valid}, 32'd1);

    // asynchronous reset between edges
    rst = 1'b1;
    #1;
    check("arst_pos",   {12'd0, position}, 32'd0);
    check("arst_valid", {31'd0, pos_valid}, 32'd0);
    #2;
    rst = 1'b0;
    step(1);
    check("post_rst_pos", {12'd0, position}, hv(368, 127));
    step(2);
    check("post_rst_e3", {31'd0, tick}, 32'd0);
    step(1);
    check("post_rst_e4", {31'd0, tick}, 32'd1);
    step(1);
    check("post_rst_move", {12'd0, position}, hv(370, 127));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
